mem_tx_streamer: RTL and testbench

// - Reads a block of bytes from the shared byte memory and streams it out through one of
//   the two UART transmitters, one byte per UART frame.
// - Complements the receive/arbitration path: that path writes Rx bytes into memory; this

---
 rtl/mem_tx_streamer_if.sv | 23 ++
 rtl/mem_tx_streamer.sv | 143 ++++++++++++++
 tb/tb_mem_tx_streamer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_tx_streamer_if.sv
// Memory read port and dual-UART transmit bundle used by mem_tx_streamer.
interface mem_tx_streamer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic [7:0]        tx_din;
  logic              tx_enable0;
  logic              tx_enable1;
  logic              tx_busy0;
  logic              tx_busy1;

  modport master (
    output mem_addr, mem_rd, tx_din, tx_enable0, tx_enable1,
    input  mem_rdata, tx_busy0, tx_busy1
  );

  modport slave (
    input  mem_addr, mem_rd, tx_din, tx_enable0, tx_enable1,
    output mem_rdata, tx_busy0, tx_busy1
  );
endinterface

// File: rtl/mem_tx_streamer.sv
// Streams a block of bytes from the shared memory out through UART0 or UART1, one byte per frame.
// Define STREAMER_CHECKSUM_EN to append an XOR checksum frame after the payload.
module mem_tx_streamer #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int BUSY_WAIT = 16
) (
  input  logic              clock_50MHz,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              dest,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  mem_tx_streamer_if.master bus
);
  localparam int WCNT_W = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_CAP, TX_IDLE, TX_PULSE, TX_RISE, TX_FALL, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q, idx;
  logic              dest_q;
  logic [WCNT_W-1:0] wcnt;
  logic              sel_busy, accept, last, wait_out, byte_sent;
  logic              cks_phase;
  logic [7:0]        cks;

`ifdef STREAMER_CHECKSUM_EN
  localparam logic CKS_EN = 1'b1;

  // cks_phase marks that the frame in flight is the checksum, not payload.
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      cks       <= '0;
      cks_phase <= 1'b0;
    end else if (accept) begin
      cks       <= '0;
      cks_phase <= (length == '0);
    end else if (state == RD_CAP) begin
      cks <= cks ^ bus.mem_rdata;
    end else if (byte_sent && last && !cks_phase) begin
      cks_phase <= 1'b1;
    end
  end
`else
  localparam logic CKS_EN = 1'b0;
  assign cks_phase = 1'b0;
  assign cks       = '0;
`endif

  assign sel_busy  = dest_q ? bus.tx_busy1 : bus.tx_busy0;
  assign accept    = (state == IDLE) && start && !busy;
  assign last      = ((idx + LEN_W'(1)) == len_q);
  assign wait_out  = (wcnt == WCNT_W'(BUSY_WAIT - 1));
  assign byte_sent = (state == TX_FALL) && !sel_busy;

  assign bus.mem_rd     = (state == RD_REQ);
  assign bus.tx_enable0 = (state == TX_PULSE) && !dest_q;
  assign bus.tx_enable1 = (state == TX_PULSE) &&  dest_q;

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (length != '0) state_nxt = RD_REQ;
          else              state_nxt = CKS_EN ? TX_IDLE : DONE;
        end
      end
      RD_REQ:   state_nxt = RD_CAP;
      RD_CAP:   state_nxt = TX_IDLE;
      TX_IDLE:  if (!sel_busy) state_nxt = TX_PULSE;
      TX_PULSE: state_nxt = TX_RISE;
      // A UART that never acknowledges is treated as having sent the byte.
      TX_RISE:  if (sel_busy || wait_out) state_nxt = TX_FALL;
      TX_FALL: begin
        if (!sel_busy) begin
          if (cks_phase || (last && !CKS_EN)) state_nxt = DONE;
          else if (last)                      state_nxt = TX_IDLE;
          else                                state_nxt = RD_REQ;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // busy stays high through the done cycle so a start there is ignored.
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      len_q        <= '0;
      idx          <= '0;
      dest_q       <= 1'b0;
      wcnt         <= '0;
      bus.mem_addr <= '0;
      bus.tx_din   <= '0;
    end else begin
      done <= (state == DONE);
      if (accept) begin
        busy         <= 1'b1;
        err_timeout  <= 1'b0;
        len_q        <= length;
        dest_q       <= dest;
        idx          <= '0;
        bus.mem_addr <= base_addr;
        if (CKS_EN && length == '0) bus.tx_din <= 8'h00;
      end else if (done) begin
        busy <= 1'b0;
      end
      case (state)
        RD_CAP:   bus.tx_din <= bus.mem_rdata;
        TX_PULSE: wcnt <= '0;
        TX_RISE: begin
          if (!sel_busy) begin
            wcnt <= wcnt + WCNT_W'(1);
            if (wait_out) err_timeout <= 1'b1;
          end
        end
        TX_FALL: begin
          if (!sel_busy && !cks_phase) begin
            idx          <= idx + LEN_W'(1);
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            if (CKS_EN && last) bus.tx_din <= cks;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_tx_streamer.sv
// Directed bench for mem_tx_streamer with a byte memory and two simple UART busy models.
module tb_mem_tx_streamer;
`ifdef STREAMER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic        start = 1'b0, start8 = 1'b0, dest = 1'b0;
  logic [31:0] base = '0;
  logic [7:0]  base8 = '0, len = '0;
  logic        busy, done, err, busy8, done8, err8;

  mem_tx_streamer_if #(.ADDR_W(32)) bus ();
  mem_tx_streamer_if #(.ADDR_W(8))  bus8 ();

  mem_tx_streamer #(.ADDR_W(32), .LEN_W(8), .BUSY_WAIT(16)) dut (
    .clock_50MHz(clk), .reset(rst), .start(start), .base_addr(base), .length(len),
    .dest(dest), .busy(busy), .done(done), .err_timeout(err), .bus(bus)
  );

  mem_tx_streamer #(.ADDR_W(8), .LEN_W(8), .BUSY_WAIT(16)) dut8 (
    .clock_50MHz(clk), .reset(rst), .start(start8), .base_addr(base8), .length(len),
    .dest(1'b0), .busy(busy8), .done(done8), .err_timeout(err8), .bus(bus8)
  );

  logic [7:0]  mem [0:255];
  int          cyc = 0, done_cnt = 0, cnt0 = 0, cnt1 = 0, din_bad = 0, en_bad = 0;
  logic        tie0 = 1'b0, hold1 = 1'b0;
  logic [7:0]  din0 = '0, din1 = '0;
  logic [7:0]  cap0[$], cap1[$], addrs8[$];
  logic [31:0] addrs[$];
  int          rd_cyc[$], en0_cyc[$], en1_cyc[$];
  int          tests = 0, fails = 0;

  assign bus.tx_busy0  = !tie0 && (cnt0 != 0);
  assign bus.tx_busy1  = hold1 || (cnt1 != 0);
  assign bus8.tx_busy0 = 1'b0;
  assign bus8.tx_busy1 = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus.mem_rd)  bus.mem_rdata  <= mem[bus.mem_addr[7:0]];
    if (bus8.mem_rd) bus8.mem_rdata <= mem[bus8.mem_addr];
    if (bus.mem_rd) begin addrs.push_back(bus.mem_addr); rd_cyc.push_back(cyc); end
    if (bus8.mem_rd) addrs8.push_back(bus8.mem_addr);
    // UART model: busy rises the cycle after the pulse and stays up for 6 cycles.
    if (bus.tx_enable0) begin
      cap0.push_back(bus.tx_din); en0_cyc.push_back(cyc); din0 <= bus.tx_din; cnt0 <= 6;
      if (bus.tx_busy0) en_bad <= en_bad + 1;
    end else if (cnt0 != 0) cnt0 <= cnt0 - 1;
    if (bus.tx_enable1) begin
      cap1.push_back(bus.tx_din); en1_cyc.push_back(cyc); din1 <= bus.tx_din; cnt1 <= 6;
      if (bus.tx_busy1) en_bad <= en_bad + 1;
    end else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    if ((bus.tx_busy0 && !bus.tx_enable0 && bus.tx_din !== din0) ||
        (cnt1 != 0 && !bus.tx_enable1 && bus.tx_din !== din1))
      din_bad <= din_bad + 1;
  end

  task automatic pulse_start(input logic [31:0] b, input logic [7:0] l, input logic d);
    @(negedge clk);
    base = b; len = l; dest = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin to = 1'b0; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++; if ({busy, done, err, bus.mem_rd, bus.tx_enable0, bus.tx_enable1} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, err, bus.mem_rd, bus.tx_enable0, bus.tx_enable1}); end
    tests++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", bus.mem_addr); end
    tests++; if (bus.tx_din !== 8'h00) begin fails++; $display("FAIL reset_din got %h want 00", bus.tx_din); end
  endtask

  task automatic test_uart0;
    logic [7:0] exp[$];
    int n0 = cap0.size(), n1 = cap1.size(), a0 = addrs.size(), d0 = done_cnt, b0 = din_bad, e0 = en_bad;
    bit to;
    mem[50] = 8'hA5; mem[51] = 8'h3C; mem[52] = 8'h0F;
    exp = '{8'hA5, 8'h3C, 8'h0F, 8'h96};
    pulse_start(32'd50, 8'd3, 1'b0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL u0_busy got %b want 1", busy); end
    wait_done(to);
    tests++; if (to) begin fails++; $display("FAIL u0_done got timeout want done"); end
    tests++; if (cap0.size() - n0 != 3 + CK) begin fails++; $display("FAIL u0_frames got %0d want %0d", cap0.size() - n0, 3 + CK); end
    for (int i = 0; i < 3 + CK && n0 + i < cap0.size(); i++) begin
      tests++; if (cap0[n0 + i] !== exp[i]) begin fails++; $display("FAIL u0_byte%0d got %h want %h", i, cap0[n0 + i], exp[i]); end
    end
    tests++; if (cap1.size() != n1) begin fails++; $display("FAIL u0_en1 got %0d pulses want 0", cap1.size() - n1); end
    tests++; if (addrs.size() - a0 != 3 || addrs[a0] !== 32'd50 || addrs[a0 + 2] !== 32'd52) begin
      fails++; $display("FAIL u0_addr got %0d reads want 50..52", addrs.size() - a0); end
    tests++; if (en0_cyc[n0] - rd_cyc[a0] != 3) begin fails++; $display("FAIL u0_latency got %0d want 3", en0_cyc[n0] - rd_cyc[a0]); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL u0_donecnt got %0d want 1", done_cnt - d0); end
    tests++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL u0_end got busy=%b err=%b want 0 0", busy, err); end
    tests++; if (din_bad != b0 || en_bad != e0) begin fails++; $display("FAIL u0_uart got din_bad=%0d en_bad=%0d want 0 0", din_bad - b0, en_bad - e0); end
  endtask

  task automatic test_wait_idle;
    int n1 = cap1.size(), n0 = cap0.size(), en_early = 0, din_chg = 0, rel;
    bit to;
    mem[60] = 8'h5A;
    hold1 = 1'b1;
    pulse_start(32'd60, 8'd1, 1'b1);
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      if (bus.tx_enable1) en_early++;
      if (i >= 4 && bus.tx_din !== 8'h5A) din_chg++;
    end
    hold1 = 1'b0; rel = cyc;
    wait_done(to);
    tests++; if (to) begin fails++; $display("FAIL wi_done got timeout want done"); end
    tests++; if (en_early != 0) begin fails++; $display("FAIL wi_early got %0d pulses want 0", en_early); end
    tests++; if (din_chg != 0) begin fails++; $display("FAIL wi_din_stable got %0d changes want 0", din_chg); end
    tests++; if (cap1.size() - n1 != 1 + CK || cap1[n1] !== 8'h5A) begin
      fails++; $display("FAIL wi_byte got %0d frames want %0d of 5a", cap1.size() - n1, 1 + CK); end
    tests++; if (en1_cyc[n1] < rel) begin fails++; $display("FAIL wi_order got cyc %0d want >= %0d", en1_cyc[n1], rel); end
    tests++; if (cap0.size() != n0) begin fails++; $display("FAIL wi_en0 got %0d want 0", cap0.size() - n0); end
  endtask

  task automatic test_zero_len;
    int n0 = cap0.size(), a0 = addrs.size();
    bit to;
    pulse_start(32'd10, 8'd0, 1'b0);
`ifdef STREAMER_CHECKSUM_EN
    wait_done(to);
    tests++; if (to) begin fails++; $display("FAIL zl_done got timeout want done"); end
    tests++; if (cap0.size() - n0 != 1 || cap0[n0] !== 8'h00) begin fails++; $display("FAIL zl_cks got %0d frames want one 00", cap0.size() - n0); end
`else
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL zl_c1 got busy=%b done=%b want 1 0", busy, done); end
    @(negedge clk);
    tests++; if (busy !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL zl_c2 got busy=%b done=%b want 1 1", busy, done); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL zl_c3 got busy=%b done=%b want 0 0", busy, done); end
    tests++; if (cap0.size() != n0) begin fails++; $display("FAIL zl_en got %0d pulses want 0", cap0.size() - n0); end
    to = 1'b0;
`endif
    tests++; if (addrs.size() != a0) begin fails++; $display("FAIL zl_rd got %0d reads want 0", addrs.size() - a0); end
  endtask

  task automatic test_busy_ignore;
    logic [7:0] exp[$];
    int n0 = cap0.size(), n1 = cap1.size(), a0 = addrs.size(), d0 = done_cnt;
    bit seen = 1'b0;
    mem[70] = 8'h11; mem[71] = 8'h22;
    for (int i = 80; i < 95; i++) mem[i] = 8'hEE;
    exp = '{8'h11, 8'h22, 8'h33};
    pulse_start(32'd70, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    base = 32'd80; len = 8'd5; dest = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    base = 32'd90; len = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (!seen) begin fails++; $display("FAIL bi_done got timeout want done"); end
    tests++; if (busy !== 1'b0 || addrs.size() - a0 != 2) begin
      fails++; $display("FAIL bi_ignored got busy=%b reads=%0d want 0 2", busy, addrs.size() - a0); end
    tests++; if (cap0.size() - n0 != 2 + CK) begin fails++; $display("FAIL bi_frames got %0d want %0d", cap0.size() - n0, 2 + CK); end
    for (int i = 0; i < 2 + CK && n0 + i < cap0.size(); i++) begin
      tests++; if (cap0[n0 + i] !== exp[i]) begin fails++; $display("FAIL bi_byte%0d got %h want %h", i, cap0[n0 + i], exp[i]); end
    end
    tests++; if (cap1.size() != n1 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL bi_side got en1=%0d done=%0d want 0 1", cap1.size() - n1, done_cnt - d0); end
  endtask

  task automatic test_timeout;
    int n0 = cap0.size(), d0 = done_cnt;
    bit to;
    mem[100] = 8'h77; mem[101] = 8'h88;
    tie0 = 1'b1;
    pulse_start(32'd100, 8'd2, 1'b0);
    wait_done(to);
    tests++; if (to) begin fails++; $display("FAIL to_done got timeout want done"); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_err got %b want 1", err); end
    tests++; if (cap0.size() - n0 != 2 + CK || cap0[n0] !== 8'h77 || cap0[n0 + 1] !== 8'h88) begin
      fails++; $display("FAIL to_frames got %0d want %0d (77 88)", cap0.size() - n0, 2 + CK); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL to_donecnt got %0d want 1", done_cnt - d0); end
    tie0 = 1'b0;
    pulse_start(32'd70, 8'd2, 1'b0);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL to_clear got %b want 0", err); end
    wait_done(to);
    tests++; if (to || err !== 1'b0) begin fails++; $display("FAIL to_clean got to=%b err=%b want 0 0", to, err); end
  endtask

  task automatic test_wrap;
    int a0 = addrs8.size();
    bit seen = 1'b0;
    mem[255] = 8'hC1; mem[0] = 8'hD2;
    @(negedge clk);
    base8 = 8'hFF; len = 8'd2; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL wr_done got timeout want done"); end
    tests++; if (addrs8.size() - a0 != 2 || addrs8[a0] !== 8'hFF || addrs8[a0 + 1] !== 8'h00) begin
      fails++; $display("FAIL wr_addr got %0d reads want ff 00", addrs8.size() - a0); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp[$];
    int n0 = cap0.size(), d0;
    bit ok = 1'b0, to;
    for (int i = 0; i < 4; i++) mem[120 + i] = 8'(i + 1);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    pulse_start(32'd120, 8'd4, 1'b0);
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (cap0.size() == n0 + 2 && bus.tx_busy0) ok = 1'b1;
    end
    @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL rm_reach got timeout want byte 2 in flight"); end
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    tests++; if ({busy, done, err, bus.mem_rd, bus.tx_enable0, bus.tx_enable1} !== 6'b0 ||
                 bus.mem_addr !== 32'h0 || bus.tx_din !== 8'h00) begin
      fails++; $display("FAIL rm_outs got busy=%b addr=%h din=%h want all 0", busy, bus.mem_addr, bus.tx_din); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL rm_nodone got %0d want 0", done_cnt - d0); end
    n0 = cap0.size();
    pulse_start(32'd120, 8'd4, 1'b0);
    wait_done(to);
    tests++; if (to || cap0.size() - n0 != 4 + CK) begin
      fails++; $display("FAIL rm_restart got to=%b frames=%0d want 0 %0d", to, cap0.size() - n0, 4 + CK); end
    for (int i = 0; i < 4 + CK && n0 + i < cap0.size(); i++) begin
      tests++; if (cap0[n0 + i] !== exp[i]) begin fails++; $display("FAIL rm_byte%0d got %h want %h", i, cap0[n0 + i], exp[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_uart0;
    test_wait_idle;
    test_zero_len;
    test_busy_ignore;
    test_timeout;
    test_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
